// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues reads to a 1-cycle-latency instruction memory,
// buffers returned words in a 2-entry FIFO and handles redirect, halt and restart.
module fetch_unit #(
    parameter int PC_W     = 11,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_rd_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr_pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            halted
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
    localparam logic [4:0]      HALT_OP    = 5'b00001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_count;
    logic            r_head;
    logic [15:0]     r_ent_instr [2];
    logic [PC_W-1:0] r_ent_pc    [2];
    logic            r_infl;
    logic [PC_W-1:0] r_infl_pc;

    logic            w_run;
    logic            w_start_go;
    logic            w_accept;
    logic [15:0]     w_head_instr;
    logic [PC_W-1:0] w_head_pc;
    logic            w_redirect;
    logic            w_halt;
    logic            w_push;
    logic [2:0]      w_occ;
    logic            w_issue;
    logic [PC_W-1:0] w_issue_addr;
    logic            w_wr_idx;

    assign w_run        = (r_state == S_RUN);
    assign w_start_go   = start && (r_state != S_RUN);
    assign w_head_instr = r_ent_instr[r_head];
    assign w_head_pc    = r_ent_pc[r_head];
    assign w_accept     = (r_count != 2'd0) && !stall;
    assign w_redirect   = w_run && branch_taken;
    // A coincident redirect overrides a halt being accepted in the same cycle.
    assign w_halt       = w_run && w_accept && (w_head_instr[15:11] == HALT_OP) && !branch_taken;
    assign w_push       = r_infl && !w_redirect && !w_halt;

    // Occupancy the FIFO will hold next cycle before any new issue returns.
    assign w_occ        = 3'(r_count) + 3'(r_infl) - 3'(w_accept);
    assign w_issue      = w_redirect || (w_run && !w_halt && (w_occ < 3'd2));
    assign w_issue_addr = w_redirect ? branch_target : r_pc;

    // Head/tail share one bit: tail = head when empty or full, the other slot when one entry.
    assign w_wr_idx     = r_head ^ r_count[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_rd_en   = 1'b0;
        imem_addr    = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    imem_rd_en = 1'b1;
                    imem_addr  = w_issue_addr;
                end
                if (w_halt) begin
                    w_state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC_V;
            r_count   <= 2'd0;
            r_head    <= 1'b0;
            r_infl    <= 1'b0;
            r_infl_pc <= '0;
            for (int i = 0; i < 2; i++) begin
                r_ent_instr[i] <= '0;
                r_ent_pc[i]    <= '0;
            end
        end else if (w_start_go) begin
            r_pc    <= RESET_PC_V;
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_infl  <= 1'b0;
        end else begin
            r_infl    <= w_issue;
            r_infl_pc <= w_issue_addr;
            if (w_issue) begin
                r_pc <= w_issue_addr + PC_W'(1);
            end
            if (w_redirect || w_halt) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_ent_instr[w_wr_idx] <= imem_rdata;
                    r_ent_pc[w_wr_idx]    <= r_infl_pc;
                end
                if (w_accept) begin
                    r_head <= ~r_head;
                end
                r_count <= r_count + 2'(w_push) - 2'(w_accept);
            end
        end
    end

    assign instr_valid = (r_count != 2'd0);
    assign instr       = instr_valid ? w_head_instr : 16'h0000;
    assign instr_pc    = instr_valid ? w_head_pc : '0;
    assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected {instr, pc} pairs are queued by the stimulus
// and a negedge monitor pops and compares on every accepted instruction.
module tb_fetch_unit;

    localparam int PC_W = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            imem_rd_en;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic [15:0]     instr;
    logic            instr_valid;
    logic [PC_W-1:0] instr_pc;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            halted;

    typedef struct packed {
        logic [15:0]     ins;
        logic [PC_W-1:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem [2048];
    int          total = 0;
    int          bad   = 0;

    fetch_unit #(.PC_W(PC_W), .RESET_PC(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous memory; garbage when not read so stray pushes are visible.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? mem[imem_addr] : 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'h2000 | 16'(i);
        end
    endtask

    task automatic push_exp(input int pc0, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc  = PC_W'((pc0 + i) & 32'h7FF);
            e.ins = mem[e.pc];
            exp_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && !halted; i++) @(negedge clk);
        chk(name, halted, 1);
    endtask

    task automatic quiet(input string name, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cnt += int'(imem_rd_en) + int'(instr_valid);
        end
        chk(name, cnt, 0);
    endtask

    // Scoreboard monitor
    initial begin
        logic            prev_hold;
        logic            prev_br;
        logic [15:0]     prev_ins;
        logic [PC_W-1:0] prev_pc;
        exp_t            e;
        prev_hold = 1'b0;
        prev_br   = 1'b0;
        prev_ins  = '0;
        prev_pc   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_hold && !prev_br && instr_valid) begin
                    chk("hold_instr", instr, prev_ins);
                    chk("hold_pc", instr_pc, prev_pc);
                end
                if (instr_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_accept: got pc=%0h instr=%0h required none", instr_pc, instr);
                    end else begin
                        e = exp_q.pop_front();
                        $display("accept pc=%0h instr=%0h (req pc=%0h instr=%0h)", instr_pc, instr, e.pc, e.ins);
                        chk("acc_instr", instr, e.ins);
                        chk("acc_pc", instr_pc, e.pc);
                    end
                end
            end
            prev_hold = !rst && instr_valid && stall;
            prev_br   = branch_taken;
            prev_ins  = instr;
            prev_pc   = instr_pc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, rd_c, v_c, vcnt, cnt;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        fill_mem();

        // Reset values
        #12;
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_halted", halted, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        quiet("idle_quiet", 3);

        // Straight line, halt at 6
        for (int i = 0; i < 6; i++) mem[i] = 16'h2001 + 16'(16'h0101 * i);
        mem[6] = 16'h0800;
        push_exp(0, 7);
        pulse_start();
        c = 0; rd_c = -1; v_c = -1;
        for (int k = 0; k < 20 && v_c < 0; k++) begin
            @(negedge clk);
            c++;
            if (rd_c < 0 && imem_rd_en) rd_c = c;
            if (instr_valid) v_c = c;
        end
        chk("latency", v_c - rd_c, 2);
        vcnt = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!instr_valid) break;
            vcnt++;
        end
        chk("stream_len", vcnt, 7);
        chk("halted_a", halted, 1);
        quiet("halted_quiet_a", 5);
        chk("drained_a", exp_q.size(), 0);

        // Halt at address 3, restart twice
        fill_mem();
        mem[3] = 16'h0800;
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 4);
            pulse_start();
            chk("halted_clear", halted, 0);
            wait_halted("halted_b", 20);
            quiet("halted_quiet_b", 5);
            chk("drained_b", exp_q.size(), 0);
        end

        // Backpressure: 5 stalled cycles mid-stream
        fill_mem();
        mem[10] = 16'h0800;
        push_exp(0, 11);
        pulse_start();
        for (int k = 0; k < 10 && !instr_valid; k++) @(negedge clk);
        tick(1);
        stall = 1'b1;
        cnt = 0; vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cnt += int'(imem_rd_en);
            vcnt += int'(instr_valid);
        end
        chk("stall_rd_en", cnt, 0);
        chk("stall_valid", vcnt, 5);
        @(posedge clk);
        #1 stall = 1'b0;
        wait_halted("halted_c", 40);
        chk("drained_c", exp_q.size(), 0);

        // Branch while buffered entry and read in flight
        fill_mem();
        mem[12'h102] = 16'h0800;
        push_exp(32'h100, 3);
        stall = 1'b1;
        pulse_start();
        tick(2);
        branch_taken = 1'b1; branch_target = 11'h100;
        @(negedge clk);
        chk("br_rd_en", imem_rd_en, 1);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_pre_pc", instr_pc, 0);
        @(posedge clk);
        #1 branch_taken = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("br_flushed", instr_valid, 0);
        wait_halted("halted_d", 20);
        chk("drained_d", exp_q.size(), 0);

        // Wrap 0x7FF -> 0x000
        fill_mem();
        mem[2] = 16'h0800;
        push_exp(32'h7FE, 5);
        pulse_start();
        branch_taken = 1'b1; branch_target = 11'h7FE;
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'h7FE);
        @(posedge clk);
        #1 branch_taken = 1'b0;
        wait_halted("halted_e", 20);
        chk("drained_e", exp_q.size(), 0);

        // Branch coincident with halt accept
        fill_mem();
        mem[2] = 16'h0800;
        mem[12'h201] = 16'h0800;
        push_exp(0, 3);
        push_exp(32'h200, 2);
        pulse_start();
        tick(4);
        branch_taken = 1'b1; branch_target = 11'h200;
        @(negedge clk);
        chk("coll_head", instr, 32'h0800);
        chk("coll_addr", imem_addr, 32'h200);
        @(posedge clk);
        #1 branch_taken = 1'b0;
        @(negedge clk);
        chk("coll_not_halted", halted, 0);
        chk("coll_rd_en", imem_rd_en, 1);
        wait_halted("halted_f", 20);
        chk("drained_f", exp_q.size(), 0);

        // Async reset between rd_en and rdata
        fill_mem();
        pulse_start();
        @(negedge clk);
        chk("pre_rst_rd_en", imem_rd_en, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_en", imem_rd_en, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_valid", instr_valid, 0);
        chk("arst_instr", instr, 0);
        chk("arst_pc", instr_pc, 0);
        chk("arst_halted", halted, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        quiet("post_rst_quiet", 8);
        chk("drained_g", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
